nibble_serial_adder: RTL
========================

// Module: nibble_serial_adder
// PURPOSE
//  Multi-cycle WIDTH-bit adder built around one 4-bit carry-look-ahead slice.
//  - Sits upstream of the 4-bit CLA slice.
//    - Feeds it one operand nibble per cycle.
//    - Registers its carry-out as the next nibble's carry-in.
//  - Sits downstream of the slice's sum: collects the result nibbles into a full-width word.
//  - Trades latency for area when wide sums are needed and only the 4-bit CLA is available.
//  - valid/ready handshake on both the input and output sides.
// PARAMETERS
//  WIDTH  16  operand/sum width in bits; must be a multiple of 4 and >= 4
//  NIB    WIDTH/4 (localparam)  number of nibble steps per addition
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operands and cin are valid
//  in_ready   out  1      block can accept operands
//  a          in   WIDTH  operand A (unsigned or two's complement)
//  b          in   WIDTH  operand B
//  cin        in   1      carry into bit 0
//  out_valid  out  1      sum/cout/overflow are valid
//  out_ready  in   1      consumer takes the result
//  sum        out  WIDTH  a+b+cin, modulo 2^WIDTH
//  cout       out  1      carry out of bit WIDTH-1
//  overflow   out  1      two's-complement signed overflow
// BEHAVIOUR
//  - Reset (rst=1 at a clk edge), regardless of the current state:
//    - FSM goes to IDLE.
//    - in_ready=1 after reset; out_valid, sum, cout, overflow, idx and the carry register all go to 0.
//    - Reset aborts any addition in progress. Nothing is emitted for it.
//  - FSM states: IDLE, RUN, DONE.
//    - IDLE: in_ready=1. On in_valid & in_ready:
//      - latch a, b into operand registers
//      - load the carry register with cin; set idx=0; go to RUN.
//    - RUN: in_ready=0, out_valid=0. Each cycle:
//      - Drive the slice with a[4*idx+:4], b[4*idx+:4] and the carry register.
//      - Write the slice sum into sum[4*idx+:4].
//      - Load the slice carry-out into the carry register; idx++.
//      - When idx==NIB-1: cout <= slice carry-out; go to DONE.
//    - DONE: out_valid=1; sum, cout and overflow are held stable.
//      - On out_ready: go to IDLE and drop out_valid.
//  - Latency: out_valid rises exactly NIB cycles after the accepting edge (NIB=4 when WIDTH=16).
//  - Throughput: one addition per NIB+2 cycles with out_ready held high.
//  - Handshake rules:
//    - in_ready is low in RUN and DONE. in_valid there is ignored and nothing is latched.
//    - out_valid, once high, stays high until taken.
//    - In DONE, sum/cout/overflow must not change while out_ready=0 (back-pressure).
//    - in_ready rises the cycle after the result is taken. No same-cycle accept-and-emit.
//  - Arithmetic:
//    - sum = (a+b+cin) mod 2^WIDTH; cout = bit WIDTH of the full sum.
//    - overflow = (a[W-1]==b[W-1]) & (sum[W-1]!=a[W-1]).
//    - overflow is computed from the latched operands. It is valid whenever out_valid=1.
//  - Boundaries:
//    - WIDTH=4: NIB=1, so RUN lasts a single cycle.
//    - Carry chain wrap: all-ones plus cin=1 ripples a carry through every nibble.
//    - sum contents during RUN are don't-care to the consumer.
//    - Operand changes after acceptance have no effect.
// STRUCTURE
//  - Shared package holds:
//    - the FSM state encoding (IDLE/RUN/DONE)
//    - the nibble width constant NIBBLE_W=4
//  - One sub-module, cla4_slice: a purely combinational 4-bit CLA.
//    - Inputs: a4, b4, ci. Outputs: s4, co.
//    - Instantiated once; it is the only adder in the block.
//  - Top level holds: FSM, idx counter ($clog2(NIB) bits, min 1), carry register,
//    operand registers, sum/cout/overflow registers.
// TESTING (WIDTH=16 unless stated)
//  1 a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, overflow=0.
//    out_valid exactly 4 cycles after accept.
//  2 a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, overflow=1.
//    a=0x8000, b=0x8000 -> sum=0x0000, cout=1, overflow=1.
//  3 Back-pressure: a=0x1234, b=0x4321, cin=1; hold out_ready=0 for 3 cycles in DONE:
//    - sum=0x5556 is held stable; in_ready=0; in_valid pulses are ignored.
//    - Accept takes effect after out_ready rises.
//  4 Reset mid-op: accept a=0xABCD, b=0x1111; assert rst on the 2nd RUN cycle:
//    - Next cycle: IDLE, in_ready=1, out_valid=0, sum=0.
//    - No result is ever emitted for that op.
//  5 Back-to-back: in_valid and out_ready held high for 100 random operand sets:
//    - Each result matches a reference model of a+b+cin.
//    - Spacing is exactly NIB+2 cycles.
//  6 WIDTH=4 build: a=0xF, b=0xF, cin=1 -> sum=0xF, cout=1, overflow=0.
//    out_valid 1 cycle after accept.

Source files
------------

// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: FSM encoding and
// the width of the single carry-look-ahead slice.
package nibble_serial_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/nibble_serial_adder_cla4_slice.sv
// Purely combinational 4-bit carry-look-ahead adder slice.
// Carries are formed directly from generate/propagate terms.
module cla4_slice
    import nibble_serial_adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a4,
    input  logic [NIBBLE_W-1:0] b4,
    input  logic                ci,
    output logic [NIBBLE_W-1:0] s4,
    output logic                co
);

    logic [NIBBLE_W-1:0] p;
    logic [NIBBLE_W-1:0] g;
    logic [NIBBLE_W:0]   c;

    assign p = a4 ^ b4;
    assign g = a4 & b4;

    assign c[0] = ci;
    assign c[1] = g[0] | (p[0] & ci);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & ci);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & ci);

    assign s4 = p ^ c[NIBBLE_W-1:0];
    assign co = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one nibble per cycle through a single
// 4-bit CLA slice, with valid/ready handshakes on both sides.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NIB  = WIDTH / NIBBLE_W;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NIB - 1);

    state_e          state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;

    logic [NIBBLE_W-1:0] sl_a, sl_b, sl_s;
    logic                sl_co;

    assign sl_a = a_q[NIBBLE_W*idx_q +: NIBBLE_W];
    assign sl_b = b_q[NIBBLE_W*idx_q +: NIBBLE_W];

    cla4_slice u_slice (
        .a4 (sl_a),
        .b4 (sl_b),
        .ci (carry_q),
        .s4 (sl_s),
        .co (sl_co)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                sum_d[NIBBLE_W*idx_q +: NIBBLE_W] = sl_s;
                carry_d = sl_co;
                idx_d   = idx_q + 1'b1;
                if (idx_q == IDX_LAST) begin
                    // Top nibble's sum bit is the result sign bit.
                    cout_d  = sl_co;
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1])
                            & (sl_s[NIBBLE_W-1] != a_q[WIDTH-1]);
                    idx_d   = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;

endmodule
